csr_timer_compare_register: RTL and testbench
=============================================

CSR_TIMER_COMPARE_REGISTER -- requirements
Module: csr_timer_compare_register

Interface
REQ-001 SHALL have parameter WIDTH, default 64, counter/compare width, legal 33..64.
REQ-002 SHALL have parameters ADDRESS_COUNT_LOWER, ADDRESS_COUNT_UPPER, ADDRESS_COMPARE_LOWER, ADDRESS_COMPARE_UPPER, ADDRESS_CONTROL, default 12'h000 each, 12-bit CSR addresses; all five SHALL be distinct.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-004 SHALL have ports: csrReadEnable in 1; csrReadAddress in 12; csrReadData out 32, combinational read data; csrRequestOutput out 1, address hit while read enabled.
REQ-005 SHALL have ports: csrWriteEnable in 1; csrWriteAddress in 12; csrWriteData in 32.
REQ-006 SHALL have ports: count in 1, increment strobe; value out WIDTH, current counter; timerInterrupt out 1, registered compare-match level.

Function
REQ-007 Control register SHALL be 32 bits: bit0 enable, bits[15:8] divisor D; all other bits read 0, writes ignored.
REQ-008 Prescaler SHALL be an 8-bit counter P: on count=1 with enable=1, P==D -> P<=0 and counter increments; else P<=P+1.
REQ-009 With D=0, counter SHALL increment on every cycle with count=1 and enable=1.
REQ-010 With enable=0, counter and P SHALL hold regardless of count.
REQ-011 Counter SHALL wrap from 2^WIDTH-1 to 0 without any flag.
REQ-012 CSR write SHALL take effect at the clock edge where csrWriteEnable=1 and the address matches; no address match -> no state change.
REQ-013 Write to COUNT_LOWER SHALL set counter[31:0]; write to COUNT_UPPER SHALL set counter[WIDTH-1:32] from csrWriteData[WIDTH-33:0]; excess data bits ignored.
REQ-014 Counter write coinciding with an increment SHALL win, the unwritten half holds its pre-edge value and no increment occurs that edge.
REQ-015 Any counter or control write SHALL clear P to 0.
REQ-016 COMPARE_LOWER/COMPARE_UPPER writes SHALL set compare halves with the same width rules as REQ-013.
REQ-017 Read of COUNT_LOWER SHALL return counter[31:0] and, at that clock edge, SHALL capture counter[WIDTH-1:32] into a shadow register.
REQ-018 Read of COUNT_UPPER SHALL return the shadow zero-extended to 32 bits (tear-free 64-bit read: lower first, then upper).
REQ-019 Reads of COMPARE_LOWER/UPPER SHALL return live compare halves, upper zero-extended; read of CONTROL returns control.
REQ-020 csrReadData SHALL be 0 when csrReadEnable=0 or the address matches none of the five.
REQ-021 csrRequestOutput SHALL be 1 iff csrReadEnable=1 and csrReadAddress matches one of the five addresses.
REQ-022 timerInterrupt SHALL be registered: next value = (counter >= compare), unsigned, evaluated on post-edge register values, so it reflects state one cycle late.
REQ-023 timerInterrupt SHALL be level only; it deasserts only when compare is raised above counter or counter wraps/is written below compare.
REQ-024 Simultaneous read and write of the same address SHALL return pre-write data.
REQ-025 value SHALL equal the counter register at all times.

Reset
REQ-026 On rst=1, asynchronously: counter 0, P 0, shadow 0, compare all ones, control 32'h0000_0001 (enabled, D=0), timerInterrupt 0.
REQ-027 With compare all ones after reset, timerInterrupt SHALL stay 0 until counter reaches 2^WIDTH-1 or compare is written.
REQ-028 Reset asserted mid-operation SHALL abandon any pending write and clear state within the same cycle, independent of clk.

Verification
REQ-029 Reset, count=1 for 10 cycles -> value=10, read COUNT_LOWER returns 10, csrRequestOutput=1.
REQ-030 Write CONTROL=32'h0000_0301 (D=3), count=1 for 12 cycles -> value=3; write CONTROL=0, 5 counts -> value unchanged.
REQ-031 WIDTH=64, write COUNT_UPPER=0, COUNT_LOWER=32'hFFFF_FFFF, one count, read lower then upper -> lower 0, upper 1; count again before upper read -> upper still shadow 1.
REQ-032 Write compare=5, count from 0 -> timerInterrupt rises one cycle after value becomes 5; write compare=100 -> falls one cycle after write.
REQ-033 WIDTH=40, write COUNT_UPPER=32'hFFFF_FFFF, COUNT_LOWER=32'hFFFF_FFFF -> read upper returns 32'h0000_00FF; one count -> value wraps to 0.
REQ-034 Assert rst asynchronously between edges while counting with timerInterrupt=1 -> value=0, timerInterrupt=0 immediately; CONTROL reads 1.

Source files
------------

// File: rtl/csr_timer_compare_register_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_compare_register_if
// Description : CSR read/write bus between a CSR master and the timer/compare
//               register block.
//               Read  : csrReadEnable, csrReadAddress[11:0] (master -> slave)
//                       csrReadData[31:0], csrRequestOutput (slave -> master)
//               Write : csrWriteEnable, csrWriteAddress[11:0],
//                       csrWriteData[31:0]                  (master -> slave)
// Revision    : 1.0  initial release
// ============================================================================
interface csr_timer_compare_register_if;
  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;

  modport master (
    output csrReadEnable, csrReadAddress,
    output csrWriteEnable, csrWriteAddress, csrWriteData,
    input  csrReadData, csrRequestOutput
  );

  modport slave (
    input  csrReadEnable, csrReadAddress,
    input  csrWriteEnable, csrWriteAddress, csrWriteData,
    output csrReadData, csrRequestOutput
  );
endinterface
`default_nettype wire

// File: rtl/csr_timer_compare_register.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_compare_register
// Description : CSR-mapped free-running timer with prescaler, compare register
//               and level interrupt. Counter and compare are WIDTH bits wide,
//               exposed as lower/upper 32-bit CSR halves. Reading COUNT_LOWER
//               snapshots the upper counter half so a following COUNT_UPPER
//               read is tear-free.
// Ports       : clk            - clock
//               rst            - asynchronous active-high reset
//               csr            - CSR read/write bus (slave modport)
//               count          - increment strobe
//               value          - current counter value
//               timerInterrupt - registered (counter >= compare) level
// Revision    : 1.0  initial release
// ============================================================================
module csr_timer_compare_register #(
  parameter int          WIDTH                 = 64,
  parameter logic [11:0] ADDRESS_COUNT_LOWER   = 12'h000,
  parameter logic [11:0] ADDRESS_COUNT_UPPER   = 12'h000,
  parameter logic [11:0] ADDRESS_COMPARE_LOWER = 12'h000,
  parameter logic [11:0] ADDRESS_COMPARE_UPPER = 12'h000,
  parameter logic [11:0] ADDRESS_CONTROL       = 12'h000
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  csr_timer_compare_register_if.slave csr,
  input  wire logic                 count,
  output logic      [WIDTH-1:0]     value,
  output logic                      timerInterrupt
);

  localparam int UPPER_WIDTH = WIDTH - 32;

  // State
  logic [WIDTH-1:0]       counter_q,   counter_d;
  logic [WIDTH-1:0]       compare_q,   compare_d;
  logic [UPPER_WIDTH-1:0] shadow_q,    shadow_d;
  logic [7:0]             prescale_q,  prescale_d;
  logic [7:0]             divisor_q,   divisor_d;
  logic                   enable_q,    enable_d;
  logic                   interrupt_q, interrupt_d;

  // Address decode
  logic w_rd_count_lo, w_rd_count_hi, w_rd_cmp_lo, w_rd_cmp_hi, w_rd_ctrl;
  logic w_wr_count_lo, w_wr_count_hi, w_wr_cmp_lo, w_wr_cmp_hi, w_wr_ctrl;
  logic w_increment;
  logic [31:0] w_control;

  assign w_rd_count_lo = csr.csrReadEnable && (csr.csrReadAddress == ADDRESS_COUNT_LOWER);
  assign w_rd_count_hi = csr.csrReadEnable && (csr.csrReadAddress == ADDRESS_COUNT_UPPER);
  assign w_rd_cmp_lo   = csr.csrReadEnable && (csr.csrReadAddress == ADDRESS_COMPARE_LOWER);
  assign w_rd_cmp_hi   = csr.csrReadEnable && (csr.csrReadAddress == ADDRESS_COMPARE_UPPER);
  assign w_rd_ctrl     = csr.csrReadEnable && (csr.csrReadAddress == ADDRESS_CONTROL);

  assign w_wr_count_lo = csr.csrWriteEnable && (csr.csrWriteAddress == ADDRESS_COUNT_LOWER);
  assign w_wr_count_hi = csr.csrWriteEnable && (csr.csrWriteAddress == ADDRESS_COUNT_UPPER);
  assign w_wr_cmp_lo   = csr.csrWriteEnable && (csr.csrWriteAddress == ADDRESS_COMPARE_LOWER);
  assign w_wr_cmp_hi   = csr.csrWriteEnable && (csr.csrWriteAddress == ADDRESS_COMPARE_UPPER);
  assign w_wr_ctrl     = csr.csrWriteEnable && (csr.csrWriteAddress == ADDRESS_CONTROL);

  assign w_control   = {16'h0000, divisor_q, 7'b0000000, enable_q};
  // Counter advances on the strobe that completes a prescaler period.
  assign w_increment = count && enable_q && (prescale_q == divisor_q);

  // Combinational read path (always returns pre-write state)
  always_comb begin
    csr.csrReadData = 32'h0000_0000;
    if (w_rd_count_lo)      csr.csrReadData = counter_q[31:0];
    else if (w_rd_count_hi) csr.csrReadData = 32'(shadow_q);
    else if (w_rd_cmp_lo)   csr.csrReadData = compare_q[31:0];
    else if (w_rd_cmp_hi)   csr.csrReadData = 32'(compare_q[WIDTH-1:32]);
    else if (w_rd_ctrl)     csr.csrReadData = w_control;
  end

  assign csr.csrRequestOutput = w_rd_count_lo | w_rd_count_hi | w_rd_cmp_lo
                              | w_rd_cmp_hi   | w_rd_ctrl;

  // Next-state logic
  always_comb begin
    counter_d   = counter_q;
    compare_d   = compare_q;
    shadow_d    = shadow_q;
    prescale_d  = prescale_q;
    divisor_d   = divisor_q;
    enable_d    = enable_q;
    // Uses pre-edge values: the interrupt lags the counter/compare by a cycle.
    interrupt_d = (counter_q >= compare_q);

    if (count && enable_q) begin
      if (prescale_q == divisor_q) prescale_d = 8'd0;
      else                         prescale_d = prescale_q + 8'd1;
    end

    if (w_increment) counter_d = counter_q + WIDTH'(1);

    // A CSR write overrides the increment; the other half keeps its old value.
    if (w_wr_count_lo) counter_d = {counter_q[WIDTH-1:32], csr.csrWriteData};
    if (w_wr_count_hi) counter_d = {csr.csrWriteData[UPPER_WIDTH-1:0], counter_q[31:0]};

    if (w_wr_cmp_lo) compare_d = {compare_q[WIDTH-1:32], csr.csrWriteData};
    if (w_wr_cmp_hi) compare_d = {csr.csrWriteData[UPPER_WIDTH-1:0], compare_q[31:0]};

    if (w_wr_ctrl) begin
      enable_d  = csr.csrWriteData[0];
      divisor_d = csr.csrWriteData[15:8];
    end

    // Restart the prescaler period whenever software touches timing state.
    if (w_wr_count_lo || w_wr_count_hi || w_wr_ctrl) prescale_d = 8'd0;

    // Snapshot the upper half as it is seen by the lower-half read.
    if (w_rd_count_lo) shadow_d = counter_q[WIDTH-1:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q   <= '0;
      compare_q   <= '1;
      shadow_q    <= '0;
      prescale_q  <= 8'd0;
      divisor_q   <= 8'd0;
      enable_q    <= 1'b1;
      interrupt_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      compare_q   <= compare_d;
      shadow_q    <= shadow_d;
      prescale_q  <= prescale_d;
      divisor_q   <= divisor_d;
      enable_q    <= enable_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign value          = counter_q;
  assign timerInterrupt = interrupt_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_timer_compare_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_timer_compare_register
// Description : Directed self-checking bench for csr_timer_compare_register.
//               DUT A uses WIDTH=64, DUT B uses WIDTH=40.
// Revision    : 1.0  initial release
// ============================================================================
module tb_csr_timer_compare_register;

  localparam logic [11:0] CL = 12'h100;
  localparam logic [11:0] CU = 12'h101;
  localparam logic [11:0] PL = 12'h102;
  localparam logic [11:0] PU = 12'h103;
  localparam logic [11:0] CT = 12'h104;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        count_a = 1'b0;
  logic        count_b = 1'b0;
  logic [63:0] value_a;
  logic [39:0] value_b;
  logic        irq_a, irq_b;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [31:0] d;
  logic        r;

  csr_timer_compare_register_if if_a ();
  csr_timer_compare_register_if if_b ();

  csr_timer_compare_register #(
    .WIDTH(64), .ADDRESS_COUNT_LOWER(CL), .ADDRESS_COUNT_UPPER(CU),
    .ADDRESS_COMPARE_LOWER(PL), .ADDRESS_COMPARE_UPPER(PU), .ADDRESS_CONTROL(CT)
  ) dut_a (
    .clk(clk), .rst(rst), .csr(if_a.slave), .count(count_a),
    .value(value_a), .timerInterrupt(irq_a)
  );

  csr_timer_compare_register #(
    .WIDTH(40), .ADDRESS_COUNT_LOWER(CL), .ADDRESS_COUNT_UPPER(CU),
    .ADDRESS_COMPARE_LOWER(PL), .ADDRESS_COMPARE_UPPER(PU), .ADDRESS_CONTROL(CT)
  ) dut_b (
    .clk(clk), .rst(rst), .csr(if_b.slave), .count(count_b),
    .value(value_b), .timerInterrupt(irq_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit b, input logic [11:0] a, input logic [31:0] data);
    if (b) begin
      if_b.csrWriteEnable = 1'b1; if_b.csrWriteAddress = a; if_b.csrWriteData = data;
    end else begin
      if_a.csrWriteEnable = 1'b1; if_a.csrWriteAddress = a; if_a.csrWriteData = data;
    end
    step();
    if_a.csrWriteEnable = 1'b0;
    if_b.csrWriteEnable = 1'b0;
  endtask

  task automatic rd(input bit b, input logic [11:0] a, output logic [31:0] data, output logic req);
    if (b) begin
      if_b.csrReadEnable = 1'b1; if_b.csrReadAddress = a;
    end else begin
      if_a.csrReadEnable = 1'b1; if_a.csrReadAddress = a;
    end
    #1;
    data = b ? if_b.csrReadData : if_a.csrReadData;
    req  = b ? if_b.csrRequestOutput : if_a.csrRequestOutput;
    step();
    if_a.csrReadEnable = 1'b0;
    if_b.csrReadEnable = 1'b0;
  endtask

  task automatic counts(input bit b, input int n);
    if (b) count_b = 1'b1; else count_a = 1'b1;
    repeat (n) step();
    count_a = 1'b0;
    count_b = 1'b0;
  endtask

  initial begin
    if_a.csrReadEnable = 0; if_a.csrReadAddress = 0;
    if_a.csrWriteEnable = 0; if_a.csrWriteAddress = 0; if_a.csrWriteData = 0;
    if_b.csrReadEnable = 0; if_b.csrReadAddress = 0;
    if_b.csrWriteEnable = 0; if_b.csrWriteAddress = 0; if_b.csrWriteData = 0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("reset_value", value_a, 64'd0);
    chk("reset_irq", {63'd0, irq_a}, 64'd0);
    if_a.csrReadEnable = 1'b1; if_a.csrReadAddress = CT;
    #1;
    chk("reset_control", {32'd0, if_a.csrReadData}, 64'd1);
    if_a.csrReadEnable = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();

    // Ten counts with D=0
    counts(0, 10);
    chk("count10_value", value_a, 64'd10);
    rd(0, CL, d, r);
    chk("count10_read", {32'd0, d}, 64'd10);
    chk("count10_req", {63'd0, r}, 64'd1);
    rd(0, 12'h3FF, d, r);
    chk("unmapped_data", {32'd0, d}, 64'd0);
    chk("unmapped_req", {63'd0, r}, 64'd0);
    chk("irq_after_reset", {63'd0, irq_a}, 64'd0);

    // Prescaler D=3 (reserved control bits written as ones)
    wr(0, CL, 32'd0);
    wr(0, CT, 32'hFFFF_0301);
    counts(0, 12);
    chk("div3_value", value_a, 64'd3);
    rd(0, CT, d, r);
    chk("control_readback", {32'd0, d}, 64'h301);
    wr(0, CT, 32'd0);
    counts(0, 5);
    chk("disabled_hold", value_a, 64'd3);
    wr(0, CT, 32'd1);

    // Carry into upper half and tear-free upper read
    wr(0, CU, 32'd0);
    wr(0, CL, 32'hFFFF_FFFF);
    counts(0, 1);
    chk("carry_value", value_a, 64'h1_0000_0000);
    rd(0, CL, d, r);
    chk("carry_lower", {32'd0, d}, 64'd0);
    rd(0, CU, d, r);
    chk("carry_upper", {32'd0, d}, 64'd1);
    wr(0, CL, 32'hFFFF_FFFF);
    rd(0, CL, d, r);
    chk("shadow_lower", {32'd0, d}, 64'hFFFF_FFFF);
    counts(0, 1);
    chk("shadow_value", value_a, 64'h2_0000_0000);
    rd(0, CU, d, r);
    chk("shadow_upper", {32'd0, d}, 64'd1);

    // Compare match timing
    wr(0, CU, 32'd0);
    wr(0, CL, 32'd0);
    wr(0, PU, 32'd0);
    wr(0, PL, 32'd5);
    counts(0, 5);
    chk("match_value", value_a, 64'd5);
    chk("match_irq_lag", {63'd0, irq_a}, 64'd0);
    step();
    chk("match_irq_rise", {63'd0, irq_a}, 64'd1);
    wr(0, PL, 32'd100);
    chk("raise_irq_lag", {63'd0, irq_a}, 64'd1);
    step();
    chk("raise_irq_fall", {63'd0, irq_a}, 64'd0);
    rd(0, PU, d, r);
    chk("compare_upper", {32'd0, d}, 64'd0);

    // Simultaneous read and write of the same address
    if_a.csrReadEnable = 1'b1; if_a.csrReadAddress = PL;
    if_a.csrWriteEnable = 1'b1; if_a.csrWriteAddress = PL; if_a.csrWriteData = 32'd200;
    #1;
    chk("rw_same_pre", {32'd0, if_a.csrReadData}, 64'd100);
    step();
    if_a.csrWriteEnable = 1'b0;
    #1;
    chk("rw_same_post", {32'd0, if_a.csrReadData}, 64'd200);
    if_a.csrReadEnable = 1'b0;
    step();

    // Write colliding with an increment
    count_a = 1'b1;
    wr(0, CL, 32'd50);
    count_a = 1'b0;
    chk("write_beats_inc", value_a, 64'd50);

    // Asynchronous reset between edges with interrupt active
    wr(0, PL, 32'd20);
    step();
    chk("pre_reset_irq", {63'd0, irq_a}, 64'd1);
    count_a = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_value", value_a, 64'd0);
    chk("async_reset_irq", {63'd0, irq_a}, 64'd0);
    if_a.csrReadEnable = 1'b1; if_a.csrReadAddress = CT;
    #1;
    chk("async_reset_control", {32'd0, if_a.csrReadData}, 64'd1);
    if_a.csrReadAddress = PL;
    #1;
    chk("async_reset_compare", {32'd0, if_a.csrReadData}, 64'hFFFF_FFFF);
    if_a.csrReadEnable = 1'b0;
    count_a = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();

    // WIDTH=40: upper-half truncation and wrap
    wr(1, CU, 32'hFFFF_FFFF);
    wr(1, CL, 32'hFFFF_FFFF);
    chk("w40_value_max", {24'd0, value_b}, 64'hFF_FFFF_FFFF);
    chk("w40_irq_lag", {63'd0, irq_b}, 64'd0);
    rd(1, CL, d, r);
    chk("w40_lower", {32'd0, d}, 64'hFFFF_FFFF);
    chk("w40_irq_at_max", {63'd0, irq_b}, 64'd1);
    rd(1, CU, d, r);
    chk("w40_upper", {32'd0, d}, 64'h0000_00FF);
    counts(1, 1);
    chk("w40_wrap", {24'd0, value_b}, 64'd0);
    chk("w40_irq_hold", {63'd0, irq_b}, 64'd1);
    step();
    chk("w40_irq_fall", {63'd0, irq_b}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
